// File: rtl/cuadro_fb_writer.sv
// cuadro_fb_writer: paints eight colour squares (4x2 grid) into the frame
// buffer write port, repainting only squares whose colour changed since
// they were last painted. One pixel write per clock while painting.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | nothing pending, write port quiet
//   S_SELECT | pick lowest dirty square, latch its colour, issue first write
//   S_PAINT  | one pixel per cycle, row-major inside the square
module cuadro_fb_writer #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int COLS  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cuadroColores0,
  input  logic [DW-1:0] cuadroColores1,
  input  logic [DW-1:0] cuadroColores2,
  input  logic [DW-1:0] cuadroColores3,
  input  logic [DW-1:0] cuadroColores4,
  input  logic [DW-1:0] cuadroColores5,
  input  logic [DW-1:0] cuadroColores6,
  input  logic [DW-1:0] cuadroColores7,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          sq_done
);

  localparam int NSQ  = 8;
  localparam int SQ_W = IMG_W / COLS;
  localparam int SQ_H = IMG_H / 2;
  localparam int XW   = $clog2(SQ_W);
  localparam int YW   = $clog2(SQ_H);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_PAINT} state_t;

  state_t        state;
  logic [DW-1:0] col_in  [NSQ];
  logic [DW-1:0] painted [NSQ];
  logic [NSQ-1:0] dirty;
  logic [NSQ-1:0] mismatch;
  logic [NSQ-1:0] pend;
  logic          any_pend;
  logic [2:0]    sel_idx;
  logic [AW-1:0] sel_base;
  logic [DW-1:0] colour;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] base;

  assign col_in[0] = cuadroColores0;
  assign col_in[1] = cuadroColores1;
  assign col_in[2] = cuadroColores2;
  assign col_in[3] = cuadroColores3;
  assign col_in[4] = cuadroColores4;
  assign col_in[5] = cuadroColores5;
  assign col_in[6] = cuadroColores6;
  assign col_in[7] = cuadroColores7;

  // Compare each requested colour against what is on screen; the combined
  // pending vector lets IDLE react in the same cycle a change arrives.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NSQ; i++) begin
      mismatch[i] = (col_in[i] != painted[i]);
    end
    pend     = dirty | mismatch;
    any_pend = |pend;
  end

  // Lowest dirty square wins, and its top-left address is the only place a
  // multiply appears (constant operands, evaluated once per square).
  always_comb begin
    sel_idx = '0;
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (dirty[i]) sel_idx = 3'(i);
    end
    sel_base = AW'((int'(sel_idx) / COLS) * SQ_H * IMG_W
                 + (int'(sel_idx) % COLS) * SQ_W);
  end

  // Dirty flags accumulate mismatches; selecting a square clears its flag
  // and records the colour that is about to be painted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty <= '1;
      for (int i = 0; i < NSQ; i++) painted[i] <= '0;
    end else begin
      dirty <= pend;
      if (state == S_SELECT) begin
        dirty[sel_idx]   <= 1'b0;
        painted[sel_idx] <= col_in[sel_idx];
      end
    end
  end

  // Sequencer: mem_addr tracks base+x incrementally so the painting loop
  // needs only adders; the write outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      sq_done  <= 1'b0;
      colour   <= '0;
      x        <= '0;
      y        <= '0;
      base     <= '0;
    end else begin
      sq_done <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          if (any_pend) begin
            state <= S_SELECT;
            busy  <= 1'b1;
          end
        end
        S_SELECT: begin
          colour   <= col_in[sel_idx];
          base     <= sel_base;
          x        <= '0;
          y        <= '0;
          mem_we   <= 1'b1;
          mem_addr <= sel_base;
          mem_data <= col_in[sel_idx];
          state    <= S_PAINT;
        end
        S_PAINT: begin
          mem_data <= colour;
          if (x == XW'(SQ_W - 1)) begin
            if (y == YW'(SQ_H - 1)) begin
              mem_we  <= 1'b0;
              sq_done <= 1'b1;
              if (any_pend) begin
                state <= S_SELECT;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              x        <= '0;
              y        <= y + YW'(1);
              base     <= base + AW'(IMG_W);
              mem_addr <= base + AW'(IMG_W);
            end
          end else begin
            x        <= x + XW'(1);
            mem_addr <= mem_addr + AW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cuadro_fb_writer.sv
// Testbench for cuadro_fb_writer: a shadow frame buffer captures every
// write; expectations come from the square geometry and the latest inputs.
module tb_cuadro_fb_writer;

  localparam int AW    = 15;
  localparam int DW    = 3;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int COLS  = 4;
  localparam int SQ_W  = IMG_W / COLS;
  localparam int SQ_H  = IMG_H / 2;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SQPIX = SQ_W * SQ_H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_col [8];
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          busy;
  logic          sq_done;

  int nerr = 0;
  int nchecks = 0;

  int cyc = 0;
  int t0 = 0;
  int nwr;
  int oor;
  int first_busy;
  int first_we;
  logic [DW-1:0] ram [NPIX];
  int wcount [NPIX];
  int wq_addr [$];
  int wq_data [$];
  int done_cyc [$];

  cuadro_fb_writer #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .cuadroColores0(in_col[0]), .cuadroColores1(in_col[1]),
    .cuadroColores2(in_col[2]), .cuadroColores3(in_col[3]),
    .cuadroColores4(in_col[4]), .cuadroColores5(in_col[5]),
    .cuadroColores6(in_col[6]), .cuadroColores7(in_col[7]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .sq_done(sq_done)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture writes and pulses mid-cycle into the shadow frame buffer.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && first_busy < 0) first_busy = cyc - t0;
      if (mem_we) begin
        if (first_we < 0) first_we = cyc - t0;
        if (int'(mem_addr) >= NPIX) oor++;
        else begin
          ram[mem_addr] = mem_data;
          wcount[mem_addr]++;
        end
        wq_addr.push_back(int'(mem_addr));
        wq_data.push_back(int'(mem_data));
        nwr++;
      end
      if (sq_done) done_cyc.push_back(cyc - t0);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchecks++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    t0 = cyc;
    nwr = 0;
    oor = 0;
    first_busy = -1;
    first_we = -1;
    for (int a = 0; a < NPIX; a++) wcount[a] = 0;
    wq_addr.delete();
    wq_data.delete();
    done_cyc.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy || mem_we) quiet = 0;
      else quiet++;
    end
    chk({tag, "_idle_in_time"}, int'(n < budget), 1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (nwr < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached_write"}, int'(nwr >= target), 1);
  endtask

  // Pixels whose shadow value differs from the colour their square requests.
  function automatic int image_errors();
    int bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      int px = a % IMG_W;
      int py = a / IMG_W;
      int sq = (py / SQ_H) * COLS + px / SQ_W;
      if (ram[a] !== in_col[sq]) bad++;
    end
    return bad;
  endfunction

  function automatic int not_once();
    int bad = 0;
    for (int a = 0; a < NPIX; a++) if (wcount[a] != 1) bad++;
    return bad;
  endfunction

  function automatic int outside_square(input int sq);
    int bad = 0;
    int xl = (sq % COLS) * SQ_W;
    int yl = (sq / COLS) * SQ_H;
    foreach (wq_addr[k]) begin
      int px = wq_addr[k] % IMG_W;
      int py = wq_addr[k] / IMG_W;
      if (px < xl || px >= xl + SQ_W || py < yl || py >= yl + SQ_H) bad++;
    end
    return bad;
  endfunction

  initial begin
    int init_cols [8] = '{7, 1, 1, 6, 3, 6, 3, 7};
    int cnt;
    for (int i = 0; i < 8; i++) in_col[i] = 3'(init_cols[i]);
    clear_stats();

    // Reset values and full-frame paint.
    repeat (3) @(negedge clk);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sq_done", int'(sq_done), 0);
    clear_stats();
    rst = 1'b0;
    wait_idle("full", 8 * (SQPIX + 1) + 100);
    chk("full_writes", nwr, NPIX);
    chk("full_not_once", not_once(), 0);
    chk("full_oor", oor, 0);
    chk("full_addr0", int'(ram[0]), 7);
    chk("full_addr9640", int'(ram[9640]), 6);
    chk("full_sq_done_n", done_cyc.size(), 8);
    if (done_cyc.size() == 8) chk("full_frame_cycles", done_cyc[7], 1 + 8 * (1 + SQPIX));
    chk("full_image", image_errors(), 0);
    chk("full_we_low", int'(mem_we), 0);

    // Quiet period: nothing changes, nothing written.
    clear_stats();
    cnt = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("hold_writes", nwr, 0);
    chk("hold_busy_cycles", cnt, 0);

    // Single square change from idle.
    clear_stats();
    in_col[5] = 3'b010;
    wait_idle("sq5", SQPIX + 100);
    chk("sq5_busy_lat", first_busy, 1);
    chk("sq5_we_lat", first_we, 2);
    chk("sq5_writes", nwr, SQPIX);
    if (nwr > 0) begin
      chk("sq5_first_addr", wq_addr[0], 9640);
      chk("sq5_first_data", wq_data[0], 2);
      chk("sq5_last_addr", wq_addr[nwr-1], 19119);
    end
    chk("sq5_outside", outside_square(5), 0);
    chk("sq5_image", image_errors(), 0);

    // Two squares change together: lower index first.
    clear_stats();
    in_col[2] = 3'b101;
    in_col[6] = 3'b000;
    wait_idle("sq26", 2 * (SQPIX + 1) + 100);
    chk("sq26_writes", nwr, 2 * SQPIX);
    if (nwr == 2 * SQPIX) begin
      chk("sq26_first_addr", wq_addr[0], 80);
      chk("sq26_second_addr", wq_addr[SQPIX], 9680);
    end
    chk("sq26_done_n", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("sq26_done_gap", done_cyc[1] - done_cyc[0], SQPIX + 1);
    chk("sq26_image", image_errors(), 0);

    // Colour of the square being painted changes mid-paint.
    clear_stats();
    in_col[0] = 3'b101;
    wait_writes("mid", 1000, 2000);
    @(posedge clk);
    #1 in_col[0] = 3'b010;
    wait_idle("mid", 2 * (SQPIX + 1) + 100);
    chk("mid_writes", nwr, 2 * SQPIX);
    if (nwr == 2 * SQPIX) begin
      cnt = 0;
      for (int k = 0; k < SQPIX; k++) if (wq_data[k] != 5) cnt++;
      chk("mid_latched_colour", cnt, 0);
      chk("mid_repaint_addr", wq_addr[SQPIX], 0);
    end
    chk("mid_addr0", int'(ram[0]), 2);
    chk("mid_image", image_errors(), 0);

    // Reset during square 3, then full repaint after release.
    rst = 1'b1;
    @(negedge clk);
    clear_stats();
    rst = 1'b0;
    wait_writes("rstmid", 3 * SQPIX + 500, 4 * (SQPIX + 1) + 100);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_we", int'(mem_we), 0);
    chk("rstmid_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    clear_stats();
    rst = 1'b0;
    wait_idle("rstmid", 8 * (SQPIX + 1) + 100);
    chk("rstmid_writes", nwr, NPIX);
    chk("rstmid_not_once", not_once(), 0);
    chk("rstmid_image", image_errors(), 0);

    // Random colour changes at random times, including mid-paint toggles.
    clear_stats();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) in_col[$urandom_range(0, 7)] = 3'($urandom_range(0, 7));
    end
    wait_idle("rand", 8 * (SQPIX + 1) + 100);
    chk("rand_oor", oor, 0);
    chk("rand_image", image_errors(), 0);
    chk("rand_whole_squares", nwr % SQPIX, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
